// File: rtl/rc4_sched_pkg.sv
// Shared types and helpers for the RC4 multicore key-space scheduler.
package rc4_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_FOUND,
    S_NO_SOL
  } state_t;

  localparam int KEY_W_DEF = 24;

  function automatic int chunk_count(input int search_w, input int chunk_log2);
    return 1 << (search_w - chunk_log2);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          hit;
  logic [PW-1:0] idx;

  always_comb begin
    gnt = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!hit && req[idx]) begin
        gnt[idx] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rc4_multicore_scheduler.sv
// Hands contiguous RC4 key chunks to idle cores, aborts on the first hit,
// and flags no_sol once every chunk has come back without one.
module rc4_multicore_scheduler
  import rc4_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int KEY_W      = KEY_W_DEF,
  parameter int SEARCH_W   = 22,
  parameter int CHUNK_LOG2 = 14
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_CORES-1:0]       core_req,
  output logic [NUM_CORES-1:0]       core_grant,
  output logic [KEY_W-1:0]           chunk_base,
  input  logic [NUM_CORES-1:0]       core_done,
  input  logic [NUM_CORES-1:0]       core_found,
  input  logic [NUM_CORES*KEY_W-1:0] core_found_key,
  output logic                       core_abort,
  output logic                       busy,
  output logic                       found,
  output logic [KEY_W-1:0]           found_key,
  output logic                       no_sol
);

  localparam int PW = $clog2(NUM_CORES);
  localparam logic [SEARCH_W:0] CHUNK_INC = (SEARCH_W+1)'(1) << CHUNK_LOG2;

  state_t               state, state_n;
  logic [SEARCH_W:0]    next_base;
  logic [NUM_CORES-1:0] outstanding, eligible, arb_gnt, grant_n, done_v, found_v;
  logic [PW-1:0]        rr_ptr, gnt_idx;
  logic [KEY_W-1:0]     win_key;
  logic                 exhausted, active, restart;

  // Extra top bit turns "all chunks handed out" into a single flag.
  assign exhausted = next_base[SEARCH_W];
  assign active    = (state == S_DISPATCH) || (state == S_DRAIN);
  assign eligible  = core_req & ~outstanding;
  assign done_v    = core_done & outstanding;
  assign found_v   = core_found & outstanding;

  rr_arbiter #(.N(NUM_CORES), .PW(PW)) u_arb (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt)
  );

  // Descending scan so the lowest-index finder wins a tie.
  always_comb begin
    win_key = '0;
    for (int i = NUM_CORES-1; i >= 0; i--)
      if (found_v[i]) win_key = core_found_key[i*KEY_W +: KEY_W];
  end

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (arb_gnt[i]) gnt_idx = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    grant_n = '0;
    restart = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          restart = 1'b1;
          state_n = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        if (|found_v)      state_n = S_FOUND;
        else if (exhausted) state_n = S_DRAIN;
        else               grant_n = arb_gnt;
      end
      S_DRAIN: begin
        if (|found_v)                          state_n = S_FOUND;
        else if ((outstanding & ~done_v) == '0) state_n = S_NO_SOL;
      end
      S_FOUND, S_NO_SOL: begin
        if (start) begin
          restart = 1'b1;
          state_n = S_DISPATCH;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      next_base   <= '0;
      outstanding <= '0;
      rr_ptr      <= '0;
      found_key   <= '0;
      core_grant  <= '0;
      chunk_base  <= '0;
    end else begin
      core_grant <= grant_n;
      chunk_base <= (|grant_n) ? KEY_W'(next_base[SEARCH_W-1:0]) : '0;
      if (restart) begin
        next_base   <= '0;
        outstanding <= '0;
        found_key   <= '0;
      end else if (active && (|found_v)) begin
        found_key   <= win_key;
        outstanding <= '0;
      end else if (active) begin
        outstanding <= (outstanding & ~done_v) | grant_n;
        if (|grant_n) begin
          next_base <= next_base + CHUNK_INC;
          rr_ptr    <= (gnt_idx == PW'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
        end
      end
    end
  end

  assign core_abort = (state == S_FOUND) || (state == S_NO_SOL);
  assign busy       = active;
  assign found      = (state == S_FOUND);
  assign no_sol     = (state == S_NO_SOL);

endmodule
